// File: rtl/arm_pkg.sv
// Shared definitions for the pick-and-place arm sequencer:
// sequencer states and default pose constants.
package arm_pkg;

  localparam int W         = 32;
  localparam int ANGLE_MAX = 180;
  localparam int HOME1     = 90;
  localparam int HOME2     = 90;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MOVE_PICK  = 3'd1,
    GRIP       = 3'd2,
    MOVE_PLACE = 3'd3,
    RELEASE    = 3'd4,
    HOME       = 3'd5
  } state_t;

endpackage

// File: rtl/arm_axis_ramp.sv
// Single-axis angle ramp: on each tick, steps toward the target by at most STEP
// and never overshoots. The register is also the commanded angle output.
module arm_axis_ramp #(
  parameter int W    = 32,
  parameter int STEP = 1,
  parameter int HOME = 90
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_home,
  input  logic         tick,
  input  logic [W-1:0] target,
  output logic [W-1:0] angle,
  output logic         at_target
);

  assign at_target = (angle == target);

  // Ramp register; unsigned distance compare keeps the final step exact
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      angle <= W'(HOME);
    end else if (load_home) begin
      angle <= W'(HOME);
    end else if (tick && (angle < target)) begin
      angle <= ((target - angle) > W'(STEP)) ? angle + W'(STEP) : target;
    end else if (tick && (angle > target)) begin
      angle <= ((angle - target) > W'(STEP)) ? angle - W'(STEP) : target;
    end else begin
      angle <= angle;
    end
  end

endmodule

// File: rtl/arm_motion_seq.sv
// Pick-and-place sequencer: ramps two joints pick -> grip -> place -> release -> home,
// driving the arm angle block directly from the ramp registers.
module arm_motion_seq #(
  parameter int W           = arm_pkg::W,
  parameter int TICK_DIV    = 50000,
  parameter int STEP        = 1,
  parameter int DWELL_TICKS = 500,
  parameter int ANGLE_MAX   = arm_pkg::ANGLE_MAX,
  parameter int HOME1       = arm_pkg::HOME1,
  parameter int HOME2       = arm_pkg::HOME2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] pick1,
  input  logic [W-1:0] pick2,
  input  logic [W-1:0] place1,
  input  logic [W-1:0] place2,
  output logic [W-1:0] xita1,
  output logic [W-1:0] xita2,
  output logic         catch,
  output logic         busy,
  output logic         done,
  output logic         aborted
);
  import arm_pkg::*;

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS + 1) : 1;

  function automatic logic [W-1:0] clamp_angle(input logic [W-1:0] a);
    clamp_angle = (a > W'(ANGLE_MAX)) ? W'(ANGLE_MAX) : a;
  endfunction

  state_t          state, state_next;
  logic [CW-1:0]   tick_cnt;
  logic [DW-1:0]   dwell_cnt;
  logic [W-1:0]    pick1_l, pick2_l, place1_l, place2_l;
  logic [W-1:0]    tgt1, tgt2;
  logic            at1, at2, tick, move_tick, entering, accept, abort_take;

  assign tick       = (tick_cnt == CW'(TICK_DIV - 1));
  assign entering   = (state_next != state);
  assign accept     = (state == IDLE) && start && !abort;
  assign abort_take = abort && (state inside {MOVE_PICK, GRIP, MOVE_PLACE, RELEASE});
  assign move_tick  = tick && (state inside {MOVE_PICK, MOVE_PLACE, HOME});

  // Next-state logic; abort takes priority over arrival and dwell expiry
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (accept) state_next = MOVE_PICK; else state_next = IDLE;
      MOVE_PICK:  if (abort) state_next = HOME;
                  else if (at1 && at2) state_next = GRIP;
                  else state_next = MOVE_PICK;
      GRIP:       if (abort) state_next = HOME;
                  else if (tick && (dwell_cnt == DW'(DWELL_TICKS - 1))) state_next = MOVE_PLACE;
                  else state_next = GRIP;
      MOVE_PLACE: if (abort) state_next = HOME;
                  else if (at1 && at2) state_next = RELEASE;
                  else state_next = MOVE_PLACE;
      RELEASE:    if (abort) state_next = HOME;
                  else if (tick && (dwell_cnt == DW'(DWELL_TICKS - 1))) state_next = HOME;
                  else state_next = RELEASE;
      HOME:       if (at1 && at2) state_next = IDLE; else state_next = HOME;
      default:    state_next = IDLE;
    endcase
  end

  // Ramp target follows the current phase
  always_comb begin
    tgt1 = W'(HOME1);
    tgt2 = W'(HOME2);
    case (state)
      MOVE_PICK:  begin tgt1 = pick1_l;  tgt2 = pick2_l;  end
      MOVE_PLACE: begin tgt1 = place1_l; tgt2 = place2_l; end
      default:    begin tgt1 = W'(HOME1); tgt2 = W'(HOME2); end
    endcase
  end

  // State register plus tick divider and dwell counter, both restarted on state entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_next;
      tick_cnt  <= (entering || tick) ? '0 : tick_cnt + CW'(1);
      dwell_cnt <= entering ? '0 : (tick ? dwell_cnt + DW'(1) : dwell_cnt);
    end
  end

  // Pose latches and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pick1_l  <= W'(HOME1);
      pick2_l  <= W'(HOME2);
      place1_l <= W'(HOME1);
      place2_l <= W'(HOME2);
      catch    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == HOME) && (state_next == IDLE) && !aborted;
      if (accept) begin
        pick1_l  <= clamp_angle(pick1);
        pick2_l  <= clamp_angle(pick2);
        place1_l <= clamp_angle(place1);
        place2_l <= clamp_angle(place2);
        aborted  <= 1'b0;
      end else if (abort_take) begin
        aborted  <= 1'b1;
      end else begin
        aborted  <= aborted;
      end
      // Gripper changes only on GRIP/RELEASE entry, so an abort leaves it as-is
      if (entering && (state_next == GRIP)) begin
        catch <= 1'b1;
      end else if (entering && (state_next == RELEASE)) begin
        catch <= 1'b0;
      end else begin
        catch <= catch;
      end
    end
  end

  arm_axis_ramp #(.W(W), .STEP(STEP), .HOME(HOME1)) u_axis1 (
    .clk(clk), .rst_n(rst_n), .load_home(state == IDLE), .tick(move_tick),
    .target(tgt1), .angle(xita1), .at_target(at1)
  );

  arm_axis_ramp #(.W(W), .STEP(STEP), .HOME(HOME2)) u_axis2 (
    .clk(clk), .rst_n(rst_n), .load_home(state == IDLE), .tick(move_tick),
    .target(tgt2), .angle(xita2), .at_target(at2)
  );

endmodule

// File: doc/arm_motion_seq.md
Name: arm_motion_seq

Overview:
Sequencer that drives the two-joint arm angle/PWM block through one complete pick-and-place cycle. After a start pulse it runs this sequence:
- ramp both joint angles to the pick pose, close the gripper and dwell;
- ramp to the place pose, open the gripper and dwell;
- return to the home pose.
Its xita1/xita2/catch outputs connect directly to the arm angle block's xita1/xita2/catch inputs. Software or a top-level FSM supplies only the poses and a start pulse.

Parameters:
W, 32, angle width (matches arm angle block xita inputs)
TICK_DIV, 50000, clk cycles per motion tick (1 ms at 50 MHz)
STEP, 1, max angle change per axis per tick
DWELL_TICKS, 500, ticks the gripper is held after close and after open
ANGLE_MAX, 180, upper clamp for any commanded angle
HOME1, 90, home angle of joint 1
HOME2, 90, home angle of joint 2

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a cycle; ignored while busy
abort  in  1  one-cycle request to abandon the cycle and go home
pick1  in  W  joint-1 pick angle, sampled on accepted start
pick2  in  W  joint-2 pick angle, sampled on accepted start
place1  in  W  joint-1 place angle, sampled on accepted start
place2  in  W  joint-2 place angle, sampled on accepted start
xita1  out  W  commanded joint-1 angle to arm angle block
xita2  out  W  commanded joint-2 angle to arm angle block
catch  out  1  gripper close command (1 = closed)
busy  out  1  high from the cycle after accept until return to IDLE
done  out  1  one-cycle pulse on normal completion
aborted  out  1  sticky flag; set on abort, cleared on next accepted start

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-low on rst_n.
- Reset values: state=IDLE, xita1=HOME1, xita2=HOME2, catch=0, busy=0, done=0, aborted=0, tick counter=0.
- States and transitions:
  - IDLE -> MOVE_PICK on start (with abort=0).
  - MOVE_PICK -> GRIP when both axes equal their targets.
  - GRIP -> MOVE_PLACE after DWELL_TICKS ticks.
  - MOVE_PLACE -> RELEASE when both axes equal their targets.
  - RELEASE -> HOME after DWELL_TICKS ticks.
  - HOME -> IDLE when both axes are at home; done pulses on this transition unless the cycle was aborted.
- Accept timing: start is accepted in IDLE at cycle N. At cycle N+1: state=MOVE_PICK, busy=1, aborted=0, tick counter=0.
- Pose latching: pick/place angles are latched at accept, each clamped to ANGLE_MAX. Input changes during a cycle have no effect.
- Tick generation: the counter counts 0..TICK_DIV-1 and wraps. The tick strobe fires when count = TICK_DIV-1. The counter resets to 0 on every state entry, so each state's first tick arrives exactly TICK_DIV cycles after entry.
- Motion states (MOVE_PICK, MOVE_PLACE, HOME): on each tick each axis moves toward its target by min(STEP, |target-current|). Axes move independently and never overshoot. Unsigned compare; no wrap-around.
- Arrival check: done combinationally every cycle. The transition happens on the next clock edge after both axes match. If the axes already match on entry, the state is left after 1 cycle.
- GRIP: catch=1 from entry. Dwell counter counts ticks; exit occurs on the tick edge where the count reaches DWELL_TICKS.
- RELEASE: catch=0 from entry. Same dwell rule as GRIP.
- catch holds its value in all other states.
- Abort: accepted in any busy state. Next state is HOME, aborted=1, catch held unchanged, no done pulse. Abort in HOME or IDLE is ignored.
- Simultaneous start+abort in IDLE: start is ignored.
- start while busy: ignored; the latched poses are not changed.
- Reset mid-cycle: all outputs return to reset values on the next edge. The angle jumps to home immediately; there is no ramp.
- xita outputs are registered and are the ramp registers themselves, so there is zero extra latency to the arm angle block.

Decomposition:
- Shared package arm_pkg holds:
  - state enum (IDLE, MOVE_PICK, GRIP, MOVE_PLACE, RELEASE, HOME);
  - default constants ANGLE_MAX, HOME1, HOME2;
  - angle width W.
- Sub-module arm_axis_ramp, instantiated twice. Inputs: clk, rst_n, load_home, tick, target. Outputs: angle, at_target. It contains the clamp-free single-axis ramp.
- Top level holds the FSM, tick divider, dwell counter and pose latches.

Test Plan:
Bench parameters: TICK_DIV=4, STEP=10, DWELL_TICKS=3, HOME=90/90.
1. Reset -> xita1=90, xita2=90, catch=0, busy=0, done=0. Start with pick=(120,60), place=(30,150). Required response:
   - joint 1 moves 90->100->110->120 and joint 2 moves 90->80->70->60, one step every 4 cycles;
   - GRIP entered; catch=1 for 12 cycles; place reached; catch=0 for 12 cycles; home reached;
   - done pulses exactly once, busy falls in the same cycle.
2. Non-multiple step: pick1=95 from 90 -> one tick produces 95 (step 5), with no overshoot to 100.
3. Clamp: pick1=500 -> joint 1 stops at 180 and MOVE_PICK completes.
4. Abort during GRIP (catch=1) -> next state HOME, catch stays 1, aborted=1, no done pulse. A following start clears aborted.
5. start pulsed while in MOVE_PLACE with new poses -> ignored; the original place pose is reached. start+abort in IDLE -> stays IDLE, busy=0.
6. Pick pose equal to home (90,90) -> MOVE_PICK exits after 1 cycle. rst_n=0 during MOVE_PLACE -> next edge xita=(90,90), catch=0, state IDLE.
